// File: rtl/poly_mult_seq.sv
// Control sequencer for a shift-register polynomial multiplier: loads the
// coefficient registers, rotates them N times and gates the accumulator.
module poly_mult_seq #(
  parameter  int N     = 4,
  parameter  int LAT   = 1,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             abort,
  output logic             csr_load,
  output logic             csr_shift,
  output logic             acc_clr,
  output logic             acc_en,
  output logic [IDX_W-1:0] coef_idx,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [7:0]       op_count
);

  localparam int STEP_W = $clog2(N + LAT + 1);
  localparam logic [STEP_W-1:0] RUN_LAST   = STEP_W'(N - 1);
  localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(N + LAT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [7:0]         op_count_q, op_count_d;
  logic               start_ready_q, start_ready_d;
  logic               csr_load_q, csr_load_d;
  logic               csr_shift_q, csr_shift_d;
  logic               acc_clr_q, acc_clr_d;
  logic               acc_en_q, acc_en_d;
  logic               busy_q, busy_d;
  logic               done_valid_q, done_valid_d;
  logic [IDX_W-1:0]   coef_idx_q, coef_idx_d;

  // step counts cycles since the first RUN cycle and keeps counting through
  // DRAIN, so the delayed accumulate window is simply step >= LAT.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: if (start_valid) state_d = LOAD;
      LOAD: begin
        step_d = '0;
        state_d = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          step_d = step_q + STEP_W'(1);
          if (step_q == RUN_LAST) state_d = (LAT == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          step_d = step_q + STEP_W'(1);
          if (step_q == DRAIN_LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d    = IDLE;
          op_count_d = op_count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    start_ready_d = (state_d == IDLE);
    csr_load_d    = (state_d == LOAD);
    acc_clr_d     = (state_d == LOAD);
    csr_shift_d   = (state_d == RUN);
    acc_en_d      = ((state_d == RUN) || (state_d == DRAIN)) && (int'(step_d) >= LAT);
    busy_d        = (state_d == LOAD) || (state_d == RUN) || (state_d == DRAIN);
    done_valid_d  = (state_d == DONE);
    coef_idx_d    = (state_d == RUN) ? step_d[IDX_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      step_q        <= '0;
      op_count_q    <= '0;
      start_ready_q <= 1'b1;
      csr_load_q    <= 1'b0;
      csr_shift_q   <= 1'b0;
      acc_clr_q     <= 1'b0;
      acc_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_valid_q  <= 1'b0;
      coef_idx_q    <= '0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      op_count_q    <= op_count_d;
      start_ready_q <= start_ready_d;
      csr_load_q    <= csr_load_d;
      csr_shift_q   <= csr_shift_d;
      acc_clr_q     <= acc_clr_d;
      acc_en_q      <= acc_en_d;
      busy_q        <= busy_d;
      done_valid_q  <= done_valid_d;
      coef_idx_q    <= coef_idx_d;
    end
  end

  assign start_ready = start_ready_q;
  assign csr_load    = csr_load_q;
  assign csr_shift   = csr_shift_q;
  assign acc_clr     = acc_clr_q;
  assign acc_en      = acc_en_q;
  assign busy        = busy_q;
  assign done_valid  = done_valid_q;
  assign coef_idx    = coef_idx_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_poly_mult_seq.sv
// Bench for poly_mult_seq: N=4/LAT=1 instance for the main scenarios plus an
// N=4/LAT=0 instance for the zero-latency timing.
module tb_poly_mult_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_valid, abort, done_ready;
  logic       start_ready, csr_load, csr_shift, acc_clr, acc_en, busy, done_valid;
  logic [1:0] coef_idx;
  logic [7:0] op_count;

  logic       start_valid0, abort0, done_ready0;
  logic       start_ready0, csr_load0, csr_shift0, acc_clr0, acc_en0, busy0, done_valid0;
  logic [1:0] coef_idx0;
  logic [7:0] op_count0;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  logic [8:0] exp_q[$];
  logic [7:0] cnt_q[$];

  localparam logic [8:0] IDLE_VEC = 9'h100;
  localparam logic [8:0] DONE_VEC = 9'h004;

  always #5 clk = ~clk;

  poly_mult_seq #(.N(4), .LAT(1)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .abort(abort), .csr_load(csr_load), .csr_shift(csr_shift), .acc_clr(acc_clr),
    .acc_en(acc_en), .coef_idx(coef_idx), .busy(busy), .done_valid(done_valid),
    .done_ready(done_ready), .op_count(op_count)
  );

  poly_mult_seq #(.N(4), .LAT(0)) dut0 (
    .clk(clk), .reset(reset), .start_valid(start_valid0), .start_ready(start_ready0),
    .abort(abort0), .csr_load(csr_load0), .csr_shift(csr_shift0), .acc_clr(acc_clr0),
    .acc_en(acc_en0), .coef_idx(coef_idx0), .busy(busy0), .done_valid(done_valid0),
    .done_ready(done_ready0), .op_count(op_count0)
  );

  // Expected outputs k cycles after the accepting cycle, derived from the timeline.
  function automatic logic [8:0] exp_vec(input int k, input int n, input int lat);
    logic sr, ld, sh, clr, ae, bz, dv;
    logic [1:0] idx;
    sr  = (k == 0);
    ld  = (k == 1);
    clr = (k == 1);
    sh  = (k >= 2) && (k <= n + 1);
    idx = sh ? 2'(k - 2) : 2'd0;
    ae  = (k >= lat + 2) && (k <= lat + n + 1);
    bz  = (k >= 1) && (k <= n + lat + 1);
    dv  = (k >= n + lat + 2);
    return {sr, ld, sh, clr, ae, bz, dv, idx};
  endfunction

  function automatic logic [8:0] obs1();
    return {start_ready, csr_load, csr_shift, acc_clr, acc_en, busy, done_valid, coef_idx};
  endfunction

  function automatic logic [8:0] obs0();
    return {start_ready0, csr_load0, csr_shift0, acc_clr0, acc_en0, busy0, done_valid0, coef_idx0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (obs1() !== IDLE_VEC) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs1(), IDLE_VEC);
    end
    n_checks++;
    if (op_count !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_op_count: got %0d expected 0", op_count);
    end
    exp_count = 0;
  endtask

  task automatic test_nominal();
    reset = 1'b1;
    start_valid = 1'b1;
    for (int k = 1; k <= 7; k++) exp_q.push_back(exp_vec(k, 4, 1));
    tick();
    start_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (obs1() !== e) begin
        n_fail++;
        $display("[TB] FAIL nominal_cycle%0d: got %h expected %h", k, obs1(), e);
      end
      if (k == 7) done_ready = 1'b1;
      tick();
    end
    done_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
    n_checks++;
    if (obs1() !== IDLE_VEC) begin
      n_fail++;
      $display("[TB] FAIL nominal_idle: got %h expected %h", obs1(), IDLE_VEC);
    end
    n_checks++;
    if (op_count !== 8'(exp_count)) begin
      n_fail++;
      $display("[TB] FAIL nominal_op_count: got %0d expected %0d", op_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    start_valid = 1'b1;
    for (int k = 1; k <= 7; k++) exp_q.push_back(exp_vec(k, 4, 1));
    tick();
    start_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (obs1() !== e) begin
        n_fail++;
        $display("[TB] FAIL bp_cycle%0d: got %h expected %h", k, obs1(), e);
      end
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      start_valid = (i == 4);
      n_checks++;
      if (obs1() !== DONE_VEC) begin
        n_fail++;
        $display("[TB] FAIL bp_hold%0d: got %h expected %h", i, obs1(), DONE_VEC);
      end
      tick();
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
    n_checks++;
    if (obs1() !== IDLE_VEC || op_count !== 8'(exp_count)) begin
      n_fail++;
      $display("[TB] FAIL bp_release: got %h/%0d expected %h/%0d", obs1(), op_count, IDLE_VEC, exp_count);
    end
    tick();
    n_checks++;
    if (obs1() !== IDLE_VEC) begin
      n_fail++;
      $display("[TB] FAIL bp_start_ignored: got %h expected %h", obs1(), IDLE_VEC);
    end
  endtask

  task automatic test_abort_run();
    start_valid = 1'b1;
    for (int k = 1; k <= 4; k++) exp_q.push_back(exp_vec(k, 4, 1));
    tick();
    start_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (obs1() !== e) begin
        n_fail++;
        $display("[TB] FAIL abort_run_cycle%0d: got %h expected %h", k, obs1(), e);
      end
      if (k == 4) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    n_checks++;
    if (obs1() !== IDLE_VEC || op_count !== 8'(exp_count)) begin
      n_fail++;
      $display("[TB] FAIL abort_run_idle: got %h/%0d expected %h/%0d", obs1(), op_count, IDLE_VEC, exp_count);
    end
    test_nominal();
  endtask

  task automatic test_reset_mid_run();
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (obs1() !== exp_vec(k, 4, 1)) begin
        n_fail++;
        $display("[TB] FAIL rst_run_cycle%0d: got %h expected %h", k, obs1(), exp_vec(k, 4, 1));
      end
      if (k == 3) reset = 1'b0;
      tick();
    end
    exp_count = 0;
    n_checks++;
    if (obs1() !== IDLE_VEC || op_count !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL rst_run_state: got %h/%0d expected %h/0", obs1(), op_count, IDLE_VEC);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_abort_drain();
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      n_checks++;
      if (obs1() !== exp_vec(k, 4, 1)) begin
        n_fail++;
        $display("[TB] FAIL abort_drain_cycle%0d: got %h expected %h", k, obs1(), exp_vec(k, 4, 1));
      end
      if (k == 6) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs1() !== IDLE_VEC || op_count !== 8'(exp_count)) begin
        n_fail++;
        $display("[TB] FAIL abort_drain_idle%0d: got %h/%0d expected %h/%0d", i, obs1(), op_count, IDLE_VEC, exp_count);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    int completed = 0;
    int cyc = 0;
    int next_expect = exp_count;
    start_valid = 1'b1;
    done_ready = 1'b1;
    while (completed < 256 && cyc < 5000) begin
      logic saw_done;
      if (start_ready && start_valid) begin
        next_expect = (next_expect + 1) % 256;
        cnt_q.push_back(8'(next_expect));
      end
      saw_done = done_valid && done_ready;
      if (completed == 255 && saw_done) start_valid = 1'b0;
      tick();
      cyc++;
      if (saw_done) begin
        logic [7:0] e;
        e = (cnt_q.size() > 0) ? cnt_q.pop_front() : 8'hxx;
        completed++;
        n_checks++;
        if (op_count !== e) begin
          n_fail++;
          $display("[TB] FAIL wrap_op%0d: got %0d expected %0d", completed, op_count, e);
        end
      end
    end
    start_valid = 1'b0;
    done_ready = 1'b0;
    exp_count = (exp_count + completed) % 256;
    n_checks++;
    if (completed != 256) begin
      n_fail++;
      $display("[TB] FAIL wrap_timeout: got %0d completions expected 256", completed);
    end
    n_checks++;
    if (op_count !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL wrap_final: got %0d expected 0", op_count);
    end
    tick();
    n_checks++;
    if (obs1() !== IDLE_VEC) begin
      n_fail++;
      $display("[TB] FAIL wrap_idle: got %h expected %h", obs1(), IDLE_VEC);
    end
  endtask

  task automatic test_lat0();
    start_valid0 = 1'b1;
    for (int k = 1; k <= 6; k++) exp_q.push_back(exp_vec(k, 4, 0));
    tick();
    start_valid0 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (obs0() !== e) begin
        n_fail++;
        $display("[TB] FAIL lat0_cycle%0d: got %h expected %h", k, obs0(), e);
      end
      n_checks++;
      if (acc_en0 !== csr_shift0) begin
        n_fail++;
        $display("[TB] FAIL lat0_acc_en%0d: got %b expected %b", k, acc_en0, csr_shift0);
      end
      if (k == 6) done_ready0 = 1'b1;
      tick();
    end
    done_ready0 = 1'b0;
    n_checks++;
    if (obs0() !== IDLE_VEC || op_count0 !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL lat0_exit: got %h/%0d expected %h/1", obs0(), op_count0, IDLE_VEC);
    end
  endtask

  initial begin
    reset = 1'b0;
    start_valid = 1'b0;
    abort = 1'b0;
    done_ready = 1'b0;
    start_valid0 = 1'b0;
    abort0 = 1'b0;
    done_ready0 = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_abort_run();
    test_reset_mid_run();
    test_abort_drain();
    test_wrap();
    test_lat0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_mult_seq.md
POLY_MULT_SEQ -- requirements
Module: poly_mult_seq

Interface
REQ-001 Parameter N, default 4: coefficient count per operand; the shift-register depth in the coefficient datapath.
REQ-002 Parameter LAT, default 1: multiply-to-accumulate pipeline latency in cycles; legal range 0..7.
REQ-003 clk  input  1: single clock; all state updates on posedge clk.
REQ-004 reset  input  1: synchronous, active-low reset; sampled on posedge clk.
REQ-005 start_valid  input  1: requester asks for one multiply operation.
REQ-006 start_ready  output  1: sequencer accepts a start this cycle.
REQ-007 abort  input  1: cancel the operation in progress.
REQ-008 csr_load  output  1: parallel-load pulse to the coefficient shift registers (active-high).
REQ-009 csr_shift  output  1: rotate-enable to the coefficient shift registers.
REQ-010 acc_clr  output  1: clear the product accumulator.
REQ-011 acc_en  output  1: accumulate the current product.
REQ-012 coef_idx  output  clog2(N): index of the coefficient presented while csr_shift=1.
REQ-013 busy  output  1: an operation is in progress (any state other than IDLE or DONE).
REQ-014 done_valid  output  1: result available; held until accepted.
REQ-015 done_ready  input  1: consumer accepts the result.
REQ-016 op_count  output  8: number of completed operations; wraps modulo 256.

Function
REQ-017 FSM states: IDLE, LOAD, RUN, DRAIN, DONE; all outputs are registered or decoded from state and counters only, with no combinational input-to-output path except start_ready.
REQ-018 IDLE: start_ready=1; start_valid=1 -> LOAD on the next cycle; otherwise remain in IDLE.
REQ-019 LOAD: lasts exactly 1 cycle; csr_load=1 and acc_clr=1 in that cycle; next state RUN.
REQ-020 RUN: lasts exactly N cycles; csr_shift=1 in every RUN cycle; coef_idx counts 0..N-1, incrementing each cycle.
REQ-021 acc_en: asserted for exactly N cycles, beginning LAT cycles after the first RUN cycle; when LAT=0, acc_en equals csr_shift.
REQ-022 DRAIN: lasts LAT cycles and carries the trailing acc_en pulses; DRAIN is skipped when LAT=0 (last RUN cycle -> DONE).
REQ-023 DONE: done_valid=1 and start_ready=0.
REQ-024 DONE exit: done_ready=1 -> IDLE on the next cycle and op_count increments by 1 (255 -> 0).
REQ-025 done_valid stays at 1 without limit while done_ready=0.
REQ-026 start_ready=0 in LOAD, RUN, DRAIN and DONE; start_valid is ignored in those states.
REQ-027 Total latency from the accepting cycle to the first done_valid cycle is 1+N+LAT+1 cycles (N=4, LAT=1: done_valid is first high 7 cycles after acceptance).
REQ-028 abort=1 in LOAD, RUN or DRAIN -> IDLE on the next cycle; csr_shift, acc_en and csr_load are 0 from that next cycle; op_count does not increment.
REQ-029 abort is ignored in IDLE and DONE.
REQ-030 Simultaneous abort and last RUN/DRAIN cycle: abort wins, so the next state is IDLE and done_valid is never asserted.
REQ-031 coef_idx holds 0 outside RUN.
REQ-032 Outputs not named as asserted in a state are 0 in that state.

Reset
REQ-033 reset=0 at a clock edge -> next state IDLE from any state, including mid-RUN and DONE.
REQ-034 Values during reset: op_count=0, coef_idx=0, and every 1-bit output is 0 except start_ready, which is 1 once in IDLE.
REQ-035 The first start is accepted in the first cycle with reset=1 and start_valid=1.

Verification
REQ-036 Nominal (N=4, LAT=1): 1-cycle start_valid pulse -> csr_load/acc_clr in cycle 1; csr_shift in cycles 2-5 with coef_idx 0,1,2,3; acc_en in cycles 3-6; done_valid from cycle 7; done_ready in cycle 7 -> IDLE in cycle 8 and op_count=1.
REQ-037 Backpressure: done_ready held 0 for 10 cycles -> done_valid remains 1, start_ready remains 0 and a start_valid pulse is ignored; done_ready=1 -> return to IDLE.
REQ-038 Abort at coef_idx=2 -> next cycle IDLE, csr_shift=0, acc_en=0, op_count unchanged; a following start gives a full nominal sequence.
REQ-039 Reset mid-RUN (reset=0 at coef_idx=1) -> IDLE, all outputs at reset values, op_count=0.
REQ-040 Wrap: 256 back-to-back operations -> op_count returns to 0; LAT=0 build -> acc_en identical to csr_shift and done_valid first high 6 cycles after acceptance.
REQ-041 Abort coincident with the final DRAIN cycle -> IDLE, done_valid never asserted, op_count unchanged.
